// File: rtl/axi_mm2s_burst_reader.sv
// AXI4 read master for the DMA MM2S path: splits a (start address, beat count) command into
// INCR bursts that never cross a 4 KB page, and forwards the read data onto an AXI-Stream output.
module axi_mm2s_burst_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_beats,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // state  | meaning
  // S_IDLE | waiting for a command, cmd_ready high
  // S_ADDR | presenting the next burst on AR
  // S_DATA | passing R beats of the outstanding burst through to the stream
  // S_FIN  | one-cycle done pulse

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int LW    = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [8:0]            len_q, len_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  error_q, error_d;

  logic [12:0]           page_beats;
  logic [LW-1:0]         rem_w;
  logic [8:0]            rem_clip;
  logic [8:0]            burst_len;
  logic                  final_burst;
  logic                  r_hs;

  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axis_tdata  = m_axi_rdata;
  assign error         = error_q;

  // Beats left in the current 4 KB page bound the burst together with MAX_BURST and the remainder.
  always_comb begin
    page_beats  = (13'h1000 - {1'b0, addr_q[11:0]}) >> SIZE;
    rem_w       = LW'(remaining_q);
    rem_clip    = (rem_w > LW'(MAX_BURST)) ? 9'(MAX_BURST) : rem_w[8:0];
    burst_len   = (page_beats < {4'b0000, rem_clip}) ? page_beats[8:0] : rem_clip;
    final_burst = (rem_w == LW'(len_q));
    r_hs        = m_axi_rvalid && m_axis_tready;
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    error_d       = error_q;
    cmd_ready     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_rready  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          remaining_d = cmd_beats;
          error_d     = 1'b0;
          state_d     = (cmd_beats == '0) ? S_FIN : S_ADDR;
        end
      end
      S_ADDR: begin
        busy          = 1'b1;
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = addr_q;
        m_axi_arlen   = 8'(burst_len - 9'd1);
        if (m_axi_arready) begin
          len_d      = burst_len;
          beat_cnt_d = burst_len;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        busy          = 1'b1;
        m_axi_rready  = m_axis_tready;
        m_axis_tvalid = m_axi_rvalid;
        m_axis_tlast  = m_axi_rvalid && final_burst && (beat_cnt_q == 9'd1);
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          if (m_axi_rresp != 2'b00) error_d = 1'b1;
          // rlast is only cross-checked; the local counter decides where the burst ends.
          if (m_axi_rlast != (beat_cnt_q == 9'd1)) error_d = 1'b1;
          if (beat_cnt_q == 9'd1) begin
            remaining_d = remaining_q - CNT_WIDTH'(len_q);
            addr_d      = addr_q + (ADDR_WIDTH'(len_q) << SIZE);
            state_d     = final_burst ? S_FIN : S_ADDR;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      error_q     <= error_d;
    end
  end

endmodule
